// File: rtl/sdram_rw_tester_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_rw_tester_if
//  Description : FIFO/SDRAM handshake bundle between the SDRAM read/write
//                tester and its write FIFO, SDRAM controller and read FIFO.
//                master : the tester (drives strobes, write data, rd_valid)
//                slave  : the FIFO/SDRAM side (drives busy, fill level, data)
//  Signals     : fifo_wr_rst_busy  write FIFO initialising
//                fifo_wr_req       write strobe to the write FIFO
//                fifo_wr_data      data word to the write FIFO
//                sdram_rd_valid    enables SDRAM -> read FIFO transfers
//                rd_fifo_cnt       read FIFO fill level
//                fifo_rd_req       read strobe to the read FIFO
//                fifo_rd_data      read FIFO data, valid 1 cycle after strobe
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdram_rw_tester_if #(
    parameter int DATA_W = 16
);
    logic              fifo_wr_rst_busy;
    logic              fifo_wr_req;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              sdram_rd_valid;
    logic [9:0]        rd_fifo_cnt;
    logic              fifo_rd_req;
    logic [DATA_W-1:0] fifo_rd_data;

    modport master (
        input  fifo_wr_rst_busy,
        input  rd_fifo_cnt,
        input  fifo_rd_data,
        output fifo_wr_req,
        output fifo_wr_data,
        output sdram_rd_valid,
        output fifo_rd_req
    );

    modport slave (
        output fifo_wr_rst_busy,
        output rd_fifo_cnt,
        output fifo_rd_data,
        input  fifo_wr_req,
        input  fifo_wr_data,
        input  sdram_rd_valid,
        input  fifo_rd_req
    );
endinterface
`default_nettype wire

// File: rtl/sdram_rw_tester.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_rw_tester
//  Description : SDRAM loopback tester. On a start pulse it writes the
//                incrementing pattern 0..WR_NUM-1 into the write FIFO (one
//                word every WR_GAP cycles), then reads CHK_NUM words back in
//                batches of RD_NUM from the read FIFO and compares each word
//                against its expected index. Mismatches set a sticky error
//                flag and a saturating 8-bit counter.
//  Ports       : clk_50M       block clock
//                locked_rst_n  asynchronous active-low reset
//                start         single-cycle run request
//                bus           FIFO/SDRAM handshake (master side)
//                done          run complete
//                error         sticky mismatch flag
//                err_cnt       mismatch count, saturates at 255
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_rw_tester #(
    parameter int DATA_W  = 16,
    parameter int WR_NUM  = 30,
    parameter int RD_NUM  = 10,
    parameter int CHK_NUM = 20,
    parameter int WR_GAP  = 8
) (
    input  logic              clk_50M,
    input  logic              locked_rst_n,
    input  logic              start,
    sdram_rw_tester_if.master bus,
    output logic              done,
    output logic              error,
    output logic [7:0]        err_cnt
);

    localparam int IDX_MAX = (WR_NUM > CHK_NUM) ? WR_NUM : CHK_NUM;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);
    localparam int GAP_W   = $clog2(WR_GAP);
    localparam int BAT_W   = $clog2(RD_NUM + 1);

    localparam logic [IDX_W-1:0] c_WR_LAST   = IDX_W'(WR_NUM - 1);
    localparam logic [IDX_W-1:0] c_CHK_NUM   = IDX_W'(CHK_NUM);
    localparam logic [GAP_W-1:0] c_GAP_LAST  = GAP_W'(WR_GAP - 1);
    localparam logic [BAT_W-1:0] c_RD_NUM    = BAT_W'(RD_NUM);
    localparam logic [9:0]       c_RD_THRESH = 10'(RD_NUM);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_READ    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_pending;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [DATA_W-1:0] r_wr_data_hold;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [BAT_W-1:0]  r_batch_cnt;
    logic [DATA_W-1:0] r_exp_word;
    logic              r_cmp_vld;
    logic              r_error;
    logic [7:0]        r_err_cnt;

    logic              w_run_start;
    logic              w_wr_req;
    logic              w_rd_req;
    logic              w_mismatch;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge locked_rst_n) begin
        if (!locked_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_run_start = 1'b0;
        w_wr_req    = 1'b0;
        w_rd_req    = 1'b0;
        case (r_state)
            // DONE behaves like IDLE for starting a new run; done stays high
            // until WRITE is actually entered.
            ST_IDLE, ST_DONE: begin
                if (r_pending && !bus.fifo_wr_rst_busy) begin
                    w_state_nxt = ST_WRITE;
                    w_run_start = 1'b1;
                end
            end
            ST_WRITE: begin
                if (!bus.fifo_wr_rst_busy && (r_gap_cnt == c_GAP_LAST)) begin
                    w_wr_req = 1'b1;
                    if (r_wr_idx == c_WR_LAST) begin
                        w_state_nxt = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (bus.rd_fifo_cnt >= c_RD_THRESH) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (r_batch_cnt != c_RD_NUM) begin
                    w_rd_req = 1'b1;
                end else if (r_rd_idx < c_CHK_NUM) begin
                    w_state_nxt = ST_WAIT_RD;
                end else begin
                    // The first cycle after the final strobe is the one whose
                    // edge performs the last compare, so DONE already shows
                    // the final error status.
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_mismatch = r_cmp_vld && (bus.fifo_rd_data != r_exp_word);

    // ------------------------------------------------------------------------
    // Datapath: start latch, write pattern, read indexing, compare
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge locked_rst_n) begin
        if (!locked_rst_n) begin
            r_pending      <= 1'b0;
            r_gap_cnt      <= '0;
            r_wr_idx       <= '0;
            r_wr_data_hold <= '0;
            r_rd_idx       <= '0;
            r_batch_cnt    <= '0;
            r_exp_word     <= '0;
            r_cmp_vld      <= 1'b0;
            r_error        <= 1'b0;
            r_err_cnt      <= '0;
        end else begin
            // Start is only accepted while no run is in flight.
            if (w_run_start) begin
                r_pending <= 1'b0;
            end else if (start && ((r_state == ST_IDLE) || (r_state == ST_DONE))) begin
                r_pending <= 1'b1;
            end

            // Gap counter freezes while the write FIFO is still initialising.
            if (w_run_start) begin
                r_gap_cnt <= '0;
            end else if ((r_state == ST_WRITE) && !bus.fifo_wr_rst_busy) begin
                r_gap_cnt <= (r_gap_cnt == c_GAP_LAST) ? '0 : r_gap_cnt + 1'b1;
            end

            if (w_run_start) begin
                r_wr_idx <= '0;
            end else if (w_wr_req) begin
                r_wr_idx       <= r_wr_idx + 1'b1;
                r_wr_data_hold <= DATA_W'(r_wr_idx);
            end

            if (w_run_start) begin
                r_rd_idx <= '0;
            end else if (w_rd_req) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end

            if (r_state != ST_READ) begin
                r_batch_cnt <= '0;
            end else if (w_rd_req) begin
                r_batch_cnt <= r_batch_cnt + 1'b1;
            end

            // Expected word travels alongside the read latency of the FIFO.
            r_cmp_vld <= w_rd_req;
            if (w_rd_req) begin
                r_exp_word <= DATA_W'(r_rd_idx);
            end

            if (w_run_start) begin
                r_error   <= 1'b0;
                r_err_cnt <= '0;
            end else if (w_mismatch) begin
                r_error <= 1'b1;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Write data shows the live index during the strobe and otherwise holds
    // the last word written, so it never moves between strobes.
    assign bus.fifo_wr_req    = w_wr_req;
    assign bus.fifo_wr_data   = w_wr_req ? DATA_W'(r_wr_idx) : r_wr_data_hold;
    assign bus.sdram_rd_valid = (r_state == ST_WAIT_RD);
    assign bus.fifo_rd_req    = w_rd_req;
    assign done               = (r_state == ST_DONE);
    assign error              = r_error;
    assign err_cnt            = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/sdram_rw_tester.md
SDRAM_RW_TESTER -- requirements
Module: sdram_rw_tester

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: width of the FIFO data words.
REQ-002 The block SHALL have parameter WR_NUM, default 30: words written per run.
REQ-003 The block SHALL have parameter RD_NUM, default 10: words read per read batch.
REQ-004 The block SHALL have parameter CHK_NUM, default 20: total words checked per run; CHK_NUM <= WR_NUM and CHK_NUM is a multiple of RD_NUM.
REQ-005 The block SHALL have parameter WR_GAP, default 8: clk_50M cycles per write slot, minimum 2.
REQ-006 The block SHALL have port clk_50M, input, 1 bit: the block clock.
REQ-007 The block SHALL have port locked_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port start, input, 1 bit: single-cycle pulse that requests a test run.
REQ-009 The block SHALL have port fifo_wr_rst_busy, input, 1 bit: high while the write FIFO is initialising.
REQ-010 The block SHALL have port fifo_wr_req, output, 1 bit: write strobe to the write FIFO.
REQ-011 The block SHALL have port fifo_wr_data, output, DATA_W bits: data word to the write FIFO.
REQ-012 The block SHALL have port sdram_rd_valid, output, 1 bit: enables SDRAM-to-read-FIFO transfers.
REQ-013 The block SHALL have port rd_fifo_cnt, input, 10 bits: current read-FIFO fill level.
REQ-014 The block SHALL have port fifo_rd_req, output, 1 bit: read strobe to the read FIFO.
REQ-015 The block SHALL have port fifo_rd_data, input, DATA_W bits: read-FIFO data, valid 1 cycle after fifo_rd_req.
REQ-016 The block SHALL have port done, output, 1 bit: high when the run is complete.
REQ-017 The block SHALL have port error, output, 1 bit: sticky mismatch flag.
REQ-018 The block SHALL have port err_cnt, output, 8 bits: mismatch count, saturating.

Function
REQ-019 The block SHALL implement the FSM states IDLE, WRITE, WAIT_RD, READ and DONE.
REQ-020 The block SHALL latch a start pulse into a pending flag, so that a start seen while fifo_wr_rst_busy=1 is not lost.
REQ-021 The block SHALL move from IDLE to WRITE when pending=1 and fifo_wr_rst_busy=0; on that move it SHALL clear pending, wr_idx, rd_idx, err_cnt and error.
REQ-022 In WRITE, the gap counter SHALL count 0..WR_GAP-1 and wrap; fifo_wr_req SHALL be 1 for exactly one cycle when the count equals WR_GAP-1.
REQ-023 In the cycle fifo_wr_req=1, fifo_wr_data SHALL equal wr_idx; wr_idx SHALL increment on the following edge; fifo_wr_data SHALL hold its value between strobes.
REQ-024 While fifo_wr_rst_busy=1 in WRITE, the gap counter SHALL freeze and no fifo_wr_req SHALL be issued.
REQ-025 After the strobe carrying wr_idx=WR_NUM-1, the FSM SHALL go to WAIT_RD and sdram_rd_valid SHALL be 1 from the next cycle.
REQ-026 In WAIT_RD, when rd_fifo_cnt >= RD_NUM, sdram_rd_valid SHALL go to 0 and the FSM SHALL go to READ on the same edge.
REQ-027 In READ, fifo_rd_req SHALL be 1 for exactly RD_NUM consecutive cycles and rd_idx SHALL increment once per strobe.
REQ-028 The expected word SHALL be rd_idx registered with the strobe; fifo_rd_data SHALL be compared with it 1 cycle after each strobe.
REQ-029 On a compare mismatch, error SHALL set and stay set until the next run, and err_cnt SHALL increment, saturating at 255.
REQ-030 After a batch in READ: if rd_idx < CHK_NUM, the FSM SHALL return to WAIT_RD and reassert sdram_rd_valid; otherwise it SHALL go to DONE once the last compare completes.
REQ-031 In DONE, done SHALL be 1 and all strobes SHALL be 0; a start pulse in DONE SHALL begin a new run through REQ-020/REQ-021, and done SHALL drop when WRITE is entered.
REQ-032 A start pulse while in WRITE, WAIT_RD or READ SHALL be ignored and SHALL NOT set pending.
REQ-033 fifo_wr_req and fifo_rd_req SHALL never be 1 in the same cycle.

Reset
REQ-034 locked_rst_n=0 SHALL asynchronously force the FSM to IDLE, all counters and pending to 0, and every output to 0 (fifo_wr_data=0, err_cnt=0).
REQ-035 Reset asserted mid-operation SHALL abort the run; after release, no strobe SHALL be issued until a new start pulse.

Verification
REQ-036 The bench SHALL cover: defaults, behavioural FIFO/SDRAM loopback, start -> 30 fifo_wr_req pulses spaced 8 cycles carrying 0..29, then 2 read batches of 10, then done=1, error=0, err_cnt=0.
REQ-037 The bench SHALL cover: fifo_rd_data forced wrong for rd_idx 3 and 15 -> error=1, err_cnt=2, done=1.
REQ-038 The bench SHALL cover: start while fifo_wr_rst_busy=1 for 50 cycles -> first fifo_wr_req occurs only after busy falls, then WR_GAP-1 cycles later.
REQ-039 The bench SHALL cover: rd_fifo_cnt held at 9 -> sdram_rd_valid stays 1 and fifo_rd_req stays 0; raising it to 10 -> sdram_rd_valid=0 and then 10 read strobes.
REQ-040 The bench SHALL cover: reset pulse after the 12th write -> all outputs 0 immediately; a subsequent start restarts fifo_wr_data from 0.
REQ-041 The bench SHALL cover: 300 forced mismatches (CHK_NUM=300, WR_NUM=300) -> err_cnt saturates at 255.
